// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM-side handshake and fields, trace handshake, register file
// write port, ID bypass and retire outputs grouped into one bundle.
interface wb_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_pc;
    logic [ADDR_WIDTH-1:0] mem_rd;
    logic                  mem_rf_wen;
    logic [1:0]            mem_wb_sel;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_alu_result;
    logic [DATA_WIDTH-1:0] mem_ld_word;
    logic                  trace_ready;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_rd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  retire_valid;
    logic [DATA_WIDTH-1:0] retire_pc;
    logic [DATA_WIDTH-1:0] retire_cnt;

    // Handshakes (mem_valid/mem_ready and retire_valid/trace_ready): a transfer happens on
    // a posedge where valid and ready are both 1; ready never depends on the same-side valid.
    modport master (
        output mem_valid, mem_pc, mem_rd, mem_rf_wen, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_ld_word, trace_ready,
        input  mem_ready, rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               retire_valid, retire_pc, retire_cnt
    );

    modport slave (
        input  mem_valid, mem_pc, mem_rd, mem_rf_wen, mem_wb_sel, mem_funct3,
               mem_alu_result, mem_ld_word, trace_ready,
        output mem_ready, rf_wen, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               retire_valid, retire_pc, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// RV32 writeback stage: one-entry WB register fed from MEM, result select with load
// extension, single register file write per instruction, bypass copy and retire counter.
module wb_stage #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 5,
    // Value the retire counter takes on reset; nonzero only to exercise the wrap.
    parameter logic [DATA_WIDTH-1:0] RETIRE_CNT_RST = '0
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);
    logic                  wb_valid_q,   wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_pc_q,      wb_pc_d;
    logic [ADDR_WIDTH-1:0] wb_rd_q,      wb_rd_d;
    logic                  wb_rf_wen_q,  wb_rf_wen_d;
    logic [1:0]            wb_sel_q,     wb_sel_d;
    logic [2:0]            wb_funct3_q,  wb_funct3_d;
    logic [DATA_WIDTH-1:0] wb_alu_q,     wb_alu_d;
    logic [DATA_WIDTH-1:0] wb_ld_word_q, wb_ld_word_d;
    logic [DATA_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    logic                  mem_ready;
    logic                  accept;
    logic                  wb_fire;
    logic                  rd_nonzero;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] result;

    always_comb begin
        mem_ready  = ~wb_valid_q | bus.trace_ready;
        wb_fire    = wb_valid_q & bus.trace_ready;
        accept     = bus.mem_valid & mem_ready;
        rd_nonzero = (wb_rd_q != '0);

        wb_valid_d   = wb_valid_q;
        wb_pc_d      = wb_pc_q;
        wb_rd_d      = wb_rd_q;
        wb_rf_wen_d  = wb_rf_wen_q;
        wb_sel_d     = wb_sel_q;
        wb_funct3_d  = wb_funct3_q;
        wb_alu_d     = wb_alu_q;
        wb_ld_word_d = wb_ld_word_q;
        retire_cnt_d = retire_cnt_q;

        // An accept in a firing cycle simply replaces the entry, giving full throughput.
        if (accept) begin
            wb_valid_d   = 1'b1;
            wb_pc_d      = bus.mem_pc;
            wb_rd_d      = bus.mem_rd;
            wb_rf_wen_d  = bus.mem_rf_wen;
            wb_sel_d     = bus.mem_wb_sel;
            wb_funct3_d  = bus.mem_funct3;
            wb_alu_d     = bus.mem_alu_result;
            wb_ld_word_d = bus.mem_ld_word;
        end else if (wb_fire) begin
            wb_valid_d = 1'b0;
        end

        if (wb_fire) begin
            retire_cnt_d = retire_cnt_q + DATA_WIDTH'(1);
        end
    end

    always_comb begin
        ld_byte   = 8'(wb_ld_word_q >> {wb_alu_q[1:0], 3'b000});
        ld_half   = 16'(wb_ld_word_q >> {wb_alu_q[1], 4'b0000});
        load_data = wb_ld_word_q;
        case (wb_funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = wb_ld_word_q;
        endcase

        result = wb_alu_q;
        case (wb_sel_q)
            2'b01:   result = load_data;
            2'b10:   result = wb_pc_q + DATA_WIDTH'(4);
            default: result = wb_alu_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_pc_q      <= '0;
            wb_rd_q      <= '0;
            wb_rf_wen_q  <= 1'b0;
            wb_sel_q     <= '0;
            wb_funct3_q  <= '0;
            wb_alu_q     <= '0;
            wb_ld_word_q <= '0;
            retire_cnt_q <= RETIRE_CNT_RST;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_pc_q      <= wb_pc_d;
            wb_rd_q      <= wb_rd_d;
            wb_rf_wen_q  <= wb_rf_wen_d;
            wb_sel_q     <= wb_sel_d;
            wb_funct3_q  <= wb_funct3_d;
            wb_alu_q     <= wb_alu_d;
            wb_ld_word_q <= wb_ld_word_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // The write is tied to wb_fire, so a stalled entry cannot write twice.
    assign bus.mem_ready    = mem_ready;
    assign bus.rf_wen       = wb_fire & wb_rf_wen_q & rd_nonzero;
    assign bus.rf_waddr     = wb_rd_q;
    assign bus.rf_wdata     = result;
    assign bus.fwd_valid    = wb_valid_q & wb_rf_wen_q & rd_nonzero;
    assign bus.fwd_rd       = wb_rd_q;
    assign bus.fwd_data     = result;
    assign bus.retire_valid = wb_fire;
    assign bus.retire_pc    = wb_pc_q;
    assign bus.retire_cnt   = retire_cnt_q;
endmodule
